// File: rtl/ped_light_ctrl_if.sv
// Signal bundle between the pedestrian controller and its environment:
// tick, button and car lamps in, pedestrian lamps and status out.
interface ped_light_ctrl_if;
  logic tick;
  logic pedReqN;
  logic redLight;
  logic yellowLight;
  logic greenLight;
  logic pedRed;
  logic pedGreen;
  logic reqPending;
  logic fault;

  modport master (
    output tick, pedReqN, redLight, yellowLight, greenLight,
    input  pedRed, pedGreen, reqPending, fault
  );

  modport slave (
    input  tick, pedReqN, redLight, yellowLight, greenLight,
    output pedRed, pedGreen, reqPending, fault
  );
endinterface

// File: rtl/ped_light_ctrl.sv
// Pedestrian crossing controller: latches button requests, runs clearance / walk / blink
// phases while the car side holds stop, and locks into a fault state on lamp conflicts.
module ped_light_ctrl #(
  parameter int unsigned SAFETY_TICKS = 10,
  parameter int unsigned WALK_TICKS   = 20,
  parameter int unsigned BLINK_TICKS  = 16,
  parameter int unsigned BLINK_HALF   = 4
) (
  input logic             clk,
  input logic             resetN,
  ped_light_ctrl_if.slave bus
);

  typedef enum logic [2:0] {StPedStop, StClear, StWalk, StBlink, StFault} state_e;

  localparam logic [7:0] SafetyLd = 8'(SAFETY_TICKS);
  localparam logic [7:0] WalkLd   = 8'(WALK_TICKS);
  localparam logic [7:0] BlinkLd  = 8'(BLINK_TICKS);
  localparam logic [7:0] HalfLd   = 8'(BLINK_HALF);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] phase_q, phase_d;
  logic       btn_q;
  logic       req_q, req_d;
  logic       red_q, red_d;
  logic       green_q, green_d;
  logic       fault_q, fault_d;

  logic car_stop, car_bad, req_evt, phase_end, walk_entry;

  assign car_stop  = bus.redLight & ~bus.yellowLight & ~bus.greenLight;
  assign car_bad   = bus.greenLight & (bus.redLight | bus.yellowLight);
  assign req_evt   = btn_q & ~bus.pedReqN;
  assign phase_end = bus.tick & (phase_q == 8'd1);

  always_ff @(posedge clk) begin
    if (resetN) begin
      state_q <= StPedStop;
      cnt_q   <= '0;
      phase_q <= '0;
      btn_q   <= 1'b1;
      req_q   <= 1'b0;
      red_q   <= 1'b1;
      green_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      btn_q   <= bus.pedReqN;
      req_q   <= req_d;
      red_q   <= red_d;
      green_q <= green_d;
      fault_q <= fault_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (car_bad) begin
      state_d = StFault;
    end else begin
      case (state_q)
        StPedStop: begin
          if (req_q && car_stop) begin
            state_d = StClear;
            cnt_d   = SafetyLd;
          end
        end
        StClear: begin
          // Losing car stop before clearance completes is a benign abort, not a fault.
          if (!car_stop) begin
            state_d = StPedStop;
          end else if (bus.tick) begin
            cnt_d = cnt_q - 8'd1;
            if (cnt_q == 8'd1) begin
              state_d = StWalk;
              cnt_d   = WalkLd;
            end
          end
        end
        StWalk: begin
          if (!car_stop) begin
            state_d = StFault;
          end else if (bus.tick) begin
            cnt_d = cnt_q - 8'd1;
            if (cnt_q == 8'd1) begin
              state_d = StBlink;
              cnt_d   = BlinkLd;
              phase_d = HalfLd;
            end
          end
        end
        StBlink: begin
          if (!car_stop) begin
            state_d = StFault;
          end else if (bus.tick) begin
            cnt_d   = cnt_q - 8'd1;
            phase_d = phase_end ? HalfLd : phase_q - 8'd1;
            if (cnt_q == 8'd1) state_d = StPedStop;
          end
        end
        StFault: state_d = StFault;
        default: state_d = StFault;
      endcase
    end
  end

  // A press landing on the walk-entry cycle survives the clear.
  assign walk_entry = (state_q == StClear) && (state_d == StWalk);

  always_comb begin
    req_d   = (state_d == StFault) ? 1'b0 : ((req_q & ~walk_entry) | req_evt);
    red_d   = (state_d == StPedStop) || (state_d == StClear) || (state_d == StFault);
    fault_d = (state_d == StFault);
    green_d = 1'b0;
    case (state_d)
      StWalk:  green_d = 1'b1;
      StBlink: green_d = (state_q != StBlink) ? 1'b1 : (green_q ^ phase_end);
      default: green_d = 1'b0;
    endcase
  end

  assign bus.pedRed     = red_q;
  assign bus.pedGreen   = green_q;
  assign bus.reqPending = req_q;
  assign bus.fault      = fault_q;

endmodule

// File: tb/tb_ped_light_ctrl.sv
// Bench for ped_light_ctrl: directed crossing scenarios with literal expectations, then
// randomized traffic checked every cycle against a phase/elapsed-tick model.
module tb_ped_light_ctrl;
  localparam int unsigned S = 10;
  localparam int unsigned W = 20;
  localparam int unsigned B = 16;
  localparam int unsigned H = 4;

  localparam int PStop  = 0;
  localparam int PClear = 1;
  localparam int PWalk  = 2;
  localparam int PBlink = 3;
  localparam int PFault = 4;

  logic clk = 1'b0;
  logic resetN = 1'b1;

  ped_light_ctrl_if bus ();

  ped_light_ctrl #(
    .SAFETY_TICKS(S),
    .WALK_TICKS  (W),
    .BLINK_TICKS (B),
    .BLINK_HALF  (H)
  ) dut (
    .clk   (clk),
    .resetN(resetN),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  task automatic check_bit(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int phase_len(input int ph);
    if (ph == PClear) return int'(S);
    if (ph == PWalk) return int'(W);
    return int'(B);
  endfunction

  // Model: which phase we are in and how many ticks have elapsed inside it.
  int m_ph = PStop;
  int m_el = 0;
  bit m_req = 1'b0;
  bit m_prev = 1'b1;

  always @(posedge clk) begin : model
    int nph, nel;
    bit stop, bad, evt, clr;
    stop = bus.redLight && !bus.yellowLight && !bus.greenLight;
    bad  = bus.greenLight && (bus.redLight || bus.yellowLight);
    evt  = m_prev && !bus.pedReqN;
    nph  = m_ph;
    nel  = m_el;
    clr  = 1'b0;
    if (bad) begin
      nph = PFault;
    end else if (m_ph == PStop) begin
      if (m_req && stop) begin
        nph = PClear;
        nel = 0;
      end
    end else if (m_ph != PFault) begin
      if (!stop) begin
        nph = (m_ph == PClear) ? PStop : PFault;
      end else if (bus.tick) begin
        nel = m_el + 1;
        if (nel == phase_len(m_ph)) begin
          nph = (m_ph == PBlink) ? PStop : m_ph + 1;
          nel = 0;
          clr = (m_ph == PClear);
        end
      end
    end
    if (resetN) begin
      m_ph   <= PStop;
      m_el   <= 0;
      m_req  <= 1'b0;
      m_prev <= 1'b1;
    end else begin
      m_ph   <= nph;
      m_el   <= nel;
      m_req  <= (nph != PFault) && ((m_req && !clr) || evt);
      m_prev <= bus.pedReqN;
    end
  end

  always @(negedge clk) begin : compare
    bit er, eg;
    if (chk_en) begin
      er = (m_ph != PWalk) && (m_ph != PBlink);
      eg = (m_ph == PWalk) || ((m_ph == PBlink) && (((m_el / int'(H)) % 2) == 0));
      check_bit("model_pedRed", bus.pedRed, er);
      check_bit("model_pedGreen", bus.pedGreen, eg);
      check_bit("model_reqPending", bus.reqPending, m_req);
      check_bit("model_fault", bus.fault, m_ph == PFault);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_car(input logic r, input logic y, input logic g);
    bus.redLight    = r;
    bus.yellowLight = y;
    bus.greenLight  = g;
  endtask

  task automatic run_len(input logic r, input logic g, output int n);
    n = 0;
    while (bus.pedRed === r && bus.pedGreen === g && n < 200) begin
      cyc();
      n++;
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check_bit({tag, "_red"}, bus.pedRed, 1'b1);
    check_bit({tag, "_green"}, bus.pedGreen, 1'b0);
    check_bit({tag, "_req"}, bus.reqPending, 1'b0);
    check_bit({tag, "_fault"}, bus.fault, 1'b0);
  endtask

  initial begin : main
    int n;
    bus.tick    = 1'b0;
    bus.pedReqN = 1'b1;
    set_car(1'b0, 1'b0, 1'b1);
    resetN = 1'b1;
    cyc();
    cyc();
    resetN = 1'b0;
    chk_en = 1'b1;
    check_reset_vals("reset");

    // Full crossing with the button held low throughout: exactly one request.
    bus.pedReqN = 1'b0;
    cyc();
    check_bit("press_latched", bus.reqPending, 1'b1);
    repeat (60) cyc();
    set_car(1'b1, 1'b0, 1'b0);
    bus.tick = 1'b1;
    cyc();
    run_len(1'b1, 1'b0, n);
    check_int("clear_ticks", n, 10);
    run_len(1'b0, 1'b1, n);
    check_int("walk_plus_first_blink_on", n, 24);
    run_len(1'b0, 1'b0, n);
    check_int("blink_off1", n, 4);
    run_len(1'b0, 1'b1, n);
    check_int("blink_on2", n, 4);
    run_len(1'b0, 1'b0, n);
    check_int("blink_off2", n, 4);
    check_bit("end_red", bus.pedRed, 1'b1);
    check_bit("held_button_single_req", bus.reqPending, 1'b0);
    bus.pedReqN = 1'b1;
    cyc();

    // Clearance abort by car yellow, then a full restart.
    bus.pedReqN = 1'b0;
    cyc();
    cyc();
    repeat (4) cyc();
    set_car(1'b0, 1'b1, 1'b0);
    cyc();
    check_bit("abort_red", bus.pedRed, 1'b1);
    check_bit("abort_req_kept", bus.reqPending, 1'b1);
    check_bit("abort_no_fault", bus.fault, 1'b0);
    repeat (3) cyc();
    set_car(1'b1, 1'b0, 1'b0);
    cyc();
    run_len(1'b1, 1'b0, n);
    check_int("restart_clear_ticks", n, 10);

    // Car leaves stop during walk: sticky fault, presses ignored.
    set_car(1'b0, 1'b0, 1'b1);
    cyc();
    check_bit("walk_fault_red", bus.pedRed, 1'b1);
    check_bit("walk_fault_green", bus.pedGreen, 1'b0);
    check_bit("walk_fault", bus.fault, 1'b1);
    bus.pedReqN = 1'b1;
    cyc();
    bus.pedReqN = 1'b0;
    cyc();
    cyc();
    set_car(1'b1, 1'b0, 1'b0);
    repeat (5) cyc();
    check_bit("fault_req_blocked", bus.reqPending, 1'b0);
    check_bit("fault_sticky", bus.fault, 1'b1);
    bus.pedReqN = 1'b1;
    resetN = 1'b1;
    cyc();
    resetN = 1'b0;
    check_reset_vals("fault_reset");

    // Press landing exactly on walk entry keeps the request alive.
    set_car(1'b0, 1'b0, 1'b1);
    bus.pedReqN = 1'b0;
    cyc();
    bus.pedReqN = 1'b1;
    set_car(1'b1, 1'b0, 1'b0);
    cyc();
    repeat (9) cyc();
    bus.pedReqN = 1'b0;
    cyc();
    check_bit("entry_press_green", bus.pedGreen, 1'b1);
    check_bit("entry_press_req", bus.reqPending, 1'b1);
    bus.pedReqN = 1'b1;
    run_len(1'b0, 1'b1, n);
    run_len(1'b0, 1'b0, n);
    run_len(1'b0, 1'b1, n);
    run_len(1'b0, 1'b0, n);
    run_len(1'b1, 1'b0, n);
    check_int("second_cycle_gap", n, 11);

    // Reset in a blink off-phase.
    repeat (26) cyc();
    check_bit("mid_blink_green_off", bus.pedGreen, 1'b0);
    check_bit("mid_blink_red_off", bus.pedRed, 1'b0);
    resetN = 1'b1;
    cyc();
    resetN = 1'b0;
    check_reset_vals("blink_reset");

    // Randomized traffic: car lamps held for random stretches, sparse ticks and presses.
    for (int seg = 0; seg < 200; seg++) begin
      int pick, len;
      pick = int'($urandom_range(0, 99));
      if (pick < 55) set_car(1'b1, 1'b0, 1'b0);
      else if (pick < 75) set_car(1'b0, 1'b0, 1'b1);
      else if (pick < 87) set_car(1'b0, 1'b1, 1'b0);
      else if (pick < 92) set_car(1'b1, 1'b1, 1'b0);
      else if (pick < 95) set_car(1'b0, 1'b0, 1'b0);
      else if (pick < 97) set_car(1'b1, 1'b0, 1'b1);
      else set_car(1'b0, 1'b1, 1'b1);
      resetN = ($urandom_range(0, 19) == 0);
      len = int'($urandom_range(1, 60));
      for (int c = 0; c < len; c++) begin
        bus.tick = ($urandom_range(0, 2) == 0);
        if ($urandom_range(0, 9) == 0) bus.pedReqN = ~bus.pedReqN;
        cyc();
        resetN = 1'b0;
      end
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ped_light_ctrl.md
PED_LIGHT_CTRL -- requirements
Module: ped_light_ctrl

Interface
REQ-001 Parameter SAFETY_TICKS, default 10: tenth-second ticks of all-red clearance before walk; legal range 1..255.
REQ-002 Parameter WALK_TICKS, default 20: steady-walk duration in ticks; legal range 1..255.
REQ-003 Parameter BLINK_TICKS, default 16: blinking-walk duration in ticks; legal range 1..255.
REQ-004 Parameter BLINK_HALF, default 4: ticks per blink half-period; legal range 1..255.
REQ-005 clk  input  1  system clock (50 MHz); all logic on rising edge.
REQ-006 resetN  input  1  reset; synchronous and active-high: asserted when 1, despite the legacy name.
REQ-007 tick  input  1  one-cycle enable pulse every 0.1 s, from the tenth-second counter.
REQ-008 pedReqN  input  1  pedestrian button, active-low, already synchronised to clk.
REQ-009 redLight  input  1  car red lamp from the traffic-light top.
REQ-010 yellowLight  input  1  car yellow lamp.
REQ-011 greenLight  input  1  car green lamp.
REQ-012 pedRed  output  1  pedestrian "don't walk" lamp.
REQ-013 pedGreen  output  1  pedestrian "walk" lamp.
REQ-014 reqPending  output  1  latched pedestrian request, not yet served.
REQ-015 fault  output  1  sticky conflict indicator.

Function
REQ-016 Car state CARSTOP SHALL be defined as redLight=1, yellowLight=0, greenLight=0.
REQ-017 Illegal car combination SHALL be defined as greenLight=1 together with redLight=1 or yellowLight=1.
REQ-018 A request SHALL be detected on a registered falling edge of pedReqN (previous sample 1, current 0), one event per press.
REQ-019 A detected request SHALL set reqPending on the next clock in every state except FAULT.
REQ-020 FSM states SHALL be PED_STOP, CLEAR, WALK, BLINK and FAULT.
REQ-021 PED_STOP: pedRed=1, pedGreen=0; go to CLEAR when reqPending=1 and CARSTOP; load the 8-bit down-counter with SAFETY_TICKS.
REQ-022 CLEAR: pedRed=1, pedGreen=0; counter decrements only on tick.
REQ-023 CLEAR exit: on the tick taking the counter from 1 to 0, go to WALK; load WALK_TICKS; clear reqPending.
REQ-024 CLEAR abort: if CARSTOP deasserts in CLEAR, return to PED_STOP with reqPending kept and fault unchanged.
REQ-025 WALK: pedRed=0, pedGreen=1; on the tick taking the counter from 1 to 0, go to BLINK; load BLINK_TICKS; load the blink phase counter with BLINK_HALF.
REQ-026 BLINK: pedRed=0; pedGreen starts at 1 on entry and toggles on every tick that takes the phase counter from 1 to 0; the phase counter reloads BLINK_HALF on each such tick.
REQ-027 BLINK exit: on the tick taking the main counter from 1 to 0, go to PED_STOP.
REQ-028 A request that sets reqPending in the same cycle it is cleared on WALK entry SHALL win, leaving reqPending=1.
REQ-029 If CARSTOP deasserts in WALK or BLINK, or an illegal car combination occurs in any state, go to FAULT on the next clock.
REQ-030 FAULT: pedRed=1, pedGreen=0, fault=1; reqPending cleared and held 0; the FSM leaves FAULT only on reset.
REQ-031 pedRed and pedGreen SHALL never both be 1, and at least one SHALL always be 1 except during a BLINK off-phase.
REQ-032 All outputs SHALL be registered, changing one clock after the qualifying tick or input edge.

Reset
REQ-033 With resetN=1 at a clock edge, the next state SHALL be PED_STOP: pedRed=1, pedGreen=0, reqPending=0, fault=0, counters 0, button edge register 1.
REQ-034 Reset asserted in any state, including FAULT and mid-count, SHALL take effect at the next edge and override all other events.

Verification
REQ-035 Press pedReqN (1->0) with car green, then car goes to CARSTOP -> reqPending=1 at once; CLEAR for exactly 10 ticks; WALK for 20 ticks; BLINK for 16 ticks; then PED_STOP with pedRed=1.
REQ-036 In BLINK with defaults -> pedGreen pattern 1,0,1,0 in 4-tick segments; pedRed stays 0.
REQ-037 Car yellow rises at tick 5 of CLEAR -> return to PED_STOP with reqPending=1 and fault=0; the next CARSTOP restarts the full 10-tick CLEAR.
REQ-038 Car leaves CARSTOP during WALK -> next clock pedGreen=0, pedRed=1, fault=1; further presses do not set reqPending; only reset clears fault.
REQ-039 Press in the exact cycle of WALK entry -> reqPending=1 after entry; a second walk cycle follows at the next CARSTOP.
REQ-040 Hold pedReqN low for 100 cycles -> exactly one request; assert reset mid-BLINK -> all outputs at reset values one clock later.
